// File: rtl/module_input_capture.sv
// Button front end: synchronises and debounces the power and send buttons, pulses a
// power toggle on each power-button release, and holds a captured instruction for the CPU.

module module_input_capture_debounce #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_i,
    output logic release_o
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          db_q;
    logic          db_d;
    logic          db_prev_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Any sample that agrees with the debounced level restarts the count.
    always_comb begin
        db_d  = db_q;
        cnt_d = '0;
        if (sync2_q != db_q) begin
            if (cnt_q == CNT_LAST) begin
                db_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            db_q      <= 1'b1;
            db_prev_q <= 1'b1;
            cnt_q     <= '0;
        end else begin
            sync1_q   <= raw_i;
            sync2_q   <= sync1_q;
            db_q      <= db_d;
            db_prev_q <= db_q;
            cnt_q     <= cnt_d;
        end
    end

    // Buttons are active-low, so a release is a rising debounced level.
    assign release_o = db_q & ~db_prev_q;
endmodule

module module_input_capture #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ligar,
    input  logic       enviar,
    input  logic [2:0] opcode,
    input  logic [3:0] addr1,
    input  logic [3:0] addr2,
    input  logic [6:0] addr3OuImm,
    input  logic       cpu_on,
    input  logic       instr_ready,
    output logic       power_toggle,
    output logic       instr_valid,
    output logic [2:0] instr_opcode,
    output logic [3:0] instr_addr1,
    output logic [3:0] instr_addr2,
    output logic [6:0] instr_addr3OuImm,
    output logic       overrun
);
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    logic       ligar_rel;
    logic       enviar_rel;
    state_t     state_q;
    logic       power_toggle_q;
    logic       overrun_q;
    logic [2:0] opcode_q;
    logic [3:0] addr1_q;
    logic [3:0] addr2_q;
    logic [6:0] addr3_q;

    module_input_capture_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db_ligar (
        .clk      (clk),
        .rst      (rst),
        .raw_i    (ligar),
        .release_o(ligar_rel)
    );

    module_input_capture_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db_enviar (
        .clk      (clk),
        .rst      (rst),
        .raw_i    (enviar),
        .release_o(enviar_rel)
    );

    // valid/ready: the held instruction is offered while in HOLD and is consumed on the
    // edge where instr_valid and instr_ready are both high; fields never change while held.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            power_toggle_q <= 1'b0;
            overrun_q      <= 1'b0;
            opcode_q       <= '0;
            addr1_q        <= '0;
            addr2_q        <= '0;
            addr3_q        <= '0;
        end else begin
            power_toggle_q <= ligar_rel;
            if (ligar_rel) begin
                state_q   <= ST_IDLE;
                overrun_q <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (enviar_rel && cpu_on) begin
                            opcode_q <= opcode;
                            addr1_q  <= addr1;
                            addr2_q  <= addr2;
                            addr3_q  <= addr3OuImm;
                            state_q  <= ST_HOLD;
                        end
                    end
                    ST_HOLD: begin
                        if (instr_ready) begin
                            state_q <= ST_IDLE;
                        end
                        // A release while holding is dropped even if the handshake completes now.
                        if (enviar_rel) begin
                            overrun_q <= 1'b1;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign power_toggle     = power_toggle_q;
    assign instr_valid      = (state_q == ST_HOLD);
    assign instr_opcode     = opcode_q;
    assign instr_addr1      = addr1_q;
    assign instr_addr2      = addr2_q;
    assign instr_addr3OuImm = addr3_q;
    assign overrun          = overrun_q;
endmodule

// File: tb/tb_module_input_capture.sv
// Bench for module_input_capture: directed scenarios plus random button traffic, all
// checked each cycle against a window-based behavioural model of the button front end.

module tb_module_input_capture;
    localparam int DC = 4;

    logic       clk;
    logic       rst;
    logic       ligar;
    logic       enviar;
    logic [2:0] opcode;
    logic [3:0] addr1;
    logic [3:0] addr2;
    logic [6:0] addr3OuImm;
    logic       cpu_on;
    logic       instr_ready;
    logic       power_toggle;
    logic       instr_valid;
    logic [2:0] instr_opcode;
    logic [3:0] instr_addr1;
    logic [3:0] instr_addr2;
    logic [6:0] instr_addr3OuImm;
    logic       overrun;

    int    n_cmp;
    int    n_fail;
    string cur_test;

    module_input_capture #(.DEBOUNCE_CYCLES(DC)) dut (
        .clk             (clk),
        .rst             (rst),
        .ligar           (ligar),
        .enviar          (enviar),
        .opcode          (opcode),
        .addr1           (addr1),
        .addr2           (addr2),
        .addr3OuImm      (addr3OuImm),
        .cpu_on          (cpu_on),
        .instr_ready     (instr_ready),
        .power_toggle    (power_toggle),
        .instr_valid     (instr_valid),
        .instr_opcode    (instr_opcode),
        .instr_addr1     (instr_addr1),
        .instr_addr2     (instr_addr2),
        .instr_addr3OuImm(instr_addr3OuImm),
        .overrun         (overrun)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Raw samples per edge; a debounced level flips once the DC samples seen by the
    // debouncer (raw delayed two edges) all disagree with it.
    bit         hl[$];
    bit         he[$];
    bit         m_db_l, m_dbp_l, m_db_e, m_dbp_e;
    logic       m_pt, m_valid, m_ov;
    logic [2:0] m_op;
    logic [3:0] m_a1, m_a2;
    logic [6:0] m_a3;

    function automatic bit flip_due(input bit is_ligar, input bit db);
        int n;
        n = is_ligar ? hl.size() : he.size();
        for (int j = 0; j < DC; j++) begin
            if ((is_ligar ? hl[n-2-j] : he[n-2-j]) == db) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_reset();
        hl.delete();
        he.delete();
        for (int i = 0; i < DC + 2; i++) begin
            hl.push_back(1'b1);
            he.push_back(1'b1);
        end
        m_db_l = 1'b1; m_dbp_l = 1'b1; m_db_e = 1'b1; m_dbp_e = 1'b1;
        m_pt = 1'b0; m_valid = 1'b0; m_ov = 1'b0;
        m_op = '0; m_a1 = '0; m_a2 = '0; m_a3 = '0;
    endtask

    task automatic model_edge();
        bit rel_l, rel_e;
        if (rst) begin
            model_reset();
        end else begin
            rel_l = m_db_l & ~m_dbp_l;
            rel_e = m_db_e & ~m_dbp_e;
            m_dbp_l = m_db_l;
            m_dbp_e = m_db_e;
            if (flip_due(1'b1, m_db_l)) m_db_l = ~m_db_l;
            if (flip_due(1'b0, m_db_e)) m_db_e = ~m_db_e;
            hl.push_back(ligar);
            he.push_back(enviar);
            if (hl.size() > DC + 2) void'(hl.pop_front());
            if (he.size() > DC + 2) void'(he.pop_front());
            m_pt = rel_l;
            if (rel_l) begin
                m_valid = 1'b0;
                m_ov    = 1'b0;
            end else if (m_valid) begin
                if (instr_ready) m_valid = 1'b0;
                if (rel_e) m_ov = 1'b1;
            end else if (rel_e && cpu_on) begin
                m_valid = 1'b1;
                m_op = opcode; m_a1 = addr1; m_a2 = addr2; m_a3 = addr3OuImm;
            end
        end
    endtask

    // One clock: advance the model with the inputs sampled at the edge, then score the DUT.
    task automatic step();
        logic [20:0] got, exp;
        @(posedge clk);
        model_edge();
        #1;
        got = {power_toggle, instr_valid, instr_opcode, instr_addr1, instr_addr2,
               instr_addr3OuImm, overrun};
        exp = {m_pt, m_valid, m_op, m_a1, m_a2, m_a3, m_ov};
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL model_%s t=%0t got=%h exp=%h", cur_test, $time, got, exp);
        end
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        cur_test = "reset";
        rst = 1'b1; ligar = 1'b0; enviar = 1'b0; cpu_on = 1'b0; instr_ready = 1'b0;
        opcode = '0; addr1 = '0; addr2 = '0; addr3OuImm = '0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++;
            if ({power_toggle, instr_valid, overrun, instr_opcode, instr_addr1, instr_addr2,
                 instr_addr3OuImm} !== 21'd0) begin
                n_fail++;
                $display("FAIL reset_outputs cycle=%0d pt=%b v=%b ov=%b op=%h required all 0",
                         i, power_toggle, instr_valid, overrun, instr_opcode);
            end
        end
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            n_cmp++;
            if (power_toggle !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_exit_toggle cycle=%0d got=%b required 0", i, power_toggle);
            end
        end
        ligar = 1'b1; enviar = 1'b1;
        steps(10);
    endtask

    task automatic test_clean_send();
        cur_test = "clean_send";
        cpu_on = 1'b1; opcode = 3'b001; addr1 = 4'h2; addr2 = 4'h3; addr3OuImm = 7'h28;
        enviar = 1'b0;
        steps(10);
        enviar = 1'b1;
        for (int i = 0; i <= 6; i++) begin
            step();
            if (i == 5) begin
                n_cmp++;
                if (instr_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL clean_early_valid at N+5 got=%b required 0", instr_valid);
                end
            end
        end
        n_cmp++;
        if (instr_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL clean_valid_rise at N+6 got=%b required 1", instr_valid);
        end
        n_cmp++;
        if ({instr_opcode, instr_addr1, instr_addr2, instr_addr3OuImm} !==
            {3'd1, 4'd2, 4'd3, 7'h28}) begin
            n_fail++;
            $display("FAIL clean_fields got=%h/%h/%h/%h required 1/2/3/28",
                     instr_opcode, instr_addr1, instr_addr2, instr_addr3OuImm);
        end
        steps(2);
        n_cmp++;
        if (instr_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL clean_hold got=%b required 1", instr_valid);
        end
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        n_cmp++;
        if (instr_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL clean_consume got=%b required 0", instr_valid);
        end
        steps(3);
    endtask

    task automatic test_bounce();
        int   rises;
        logic prev_v;
        cur_test = "bounce";
        cpu_on = 1'b1;
        opcode = 3'($urandom); addr1 = 4'($urandom); addr2 = 4'($urandom);
        addr3OuImm = 7'($urandom);
        enviar = 1'b0;
        steps(10);
        for (int i = 0; i < 4; i++) begin
            enviar = (i % 2 == 0) ? 1'b1 : 1'b0;
            step();
            n_cmp++;
            if (instr_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL bounce_early_capture i=%0d got=%b required 0", i, instr_valid);
            end
        end
        enviar = 1'b1;
        rises = 0;
        prev_v = instr_valid;
        for (int i = 0; i < 14; i++) begin
            step();
            if (instr_valid === 1'b1 && prev_v !== 1'b1) rises++;
            prev_v = instr_valid;
        end
        n_cmp++;
        if (rises != 1) begin
            n_fail++;
            $display("FAIL bounce_capture_count got=%0d required 1", rises);
        end
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        steps(2);
    endtask

    task automatic test_overrun();
        int pulses;
        cur_test = "overrun";
        cpu_on = 1'b1; opcode = 3'b001; addr1 = 4'h5; addr2 = 4'h6; addr3OuImm = 7'h11;
        enviar = 1'b0; steps(8);
        enviar = 1'b1; steps(8);
        n_cmp++;
        if (instr_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL overrun_first_capture got=%b required 1", instr_valid);
        end
        opcode = 3'b111;
        enviar = 1'b0; steps(8);
        enviar = 1'b1; steps(8);
        n_cmp++;
        if ({instr_valid, instr_opcode, overrun} !== {1'b1, 3'd1, 1'b1}) begin
            n_fail++;
            $display("FAIL overrun_held got v=%b op=%0d ov=%b required v=1 op=1 ov=1",
                     instr_valid, instr_opcode, overrun);
        end
        ligar = 1'b0; steps(8);
        ligar = 1'b1;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (power_toggle === 1'b1) pulses++;
        end
        n_cmp++;
        if ({pulses == 1, instr_valid, overrun} !== 3'b100) begin
            n_fail++;
            $display("FAIL overrun_flush got pulses=%0d v=%b ov=%b required 1/0/0",
                     pulses, instr_valid, overrun);
        end
    endtask

    task automatic test_power_off();
        bit seen_v;
        cur_test = "power_off";
        cpu_on = 1'b0;
        enviar = 1'b0; steps(8);
        enviar = 1'b1;
        seen_v = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (instr_valid !== 1'b0) seen_v = 1'b1;
        end
        n_cmp++;
        if ({seen_v, overrun} !== 2'b00) begin
            n_fail++;
            $display("FAIL power_off got seen_valid=%b ov=%b required 0/0", seen_v, overrun);
        end
    endtask

    task automatic test_coincident();
        int pulses;
        bit seen_v;
        cur_test = "coincident";
        cpu_on = 1'b1;
        ligar = 1'b0; enviar = 1'b0; steps(8);
        ligar = 1'b1; enviar = 1'b1;
        pulses = 0; seen_v = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (power_toggle === 1'b1) pulses++;
            if (instr_valid !== 1'b0) seen_v = 1'b1;
        end
        n_cmp++;
        if (pulses != 1 || seen_v) begin
            n_fail++;
            $display("FAIL coincident got pulses=%0d seen_valid=%b required 1/0", pulses, seen_v);
        end
        enviar = 1'b0; steps(8);
        enviar = 1'b1; steps(8);
        n_cmp++;
        if (instr_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_hold_setup got=%b required 1", instr_valid);
        end
        ligar = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_cmp++;
        if ({power_toggle, instr_valid, overrun, instr_opcode, instr_addr1, instr_addr2,
             instr_addr3OuImm} !== 21'd0) begin
            n_fail++;
            $display("FAIL rst_in_hold got v=%b op=%h required all 0", instr_valid, instr_opcode);
        end
        for (int i = 0; i < 8; i++) begin
            step();
            n_cmp++;
            if (power_toggle !== 1'b0) begin
                n_fail++;
                $display("FAIL rst_exit_held_button cycle=%0d got=%b required 0", i, power_toggle);
            end
        end
        ligar = 1'b1;
        steps(10);
    endtask

    task automatic test_random();
        int hold_l, hold_e;
        cur_test = "random";
        hold_l = 20; hold_e = 3;
        for (int i = 0; i < 600; i++) begin
            if (hold_l == 0) begin
                ligar = ~ligar;
                hold_l = (ligar == 1'b1) ? $urandom_range(1, 60) : $urandom_range(1, 8);
            end else begin
                hold_l--;
            end
            if (hold_e == 0) begin
                enviar = ~enviar;
                hold_e = $urandom_range(1, 9);
            end else begin
                hold_e--;
            end
            if ($urandom_range(0, 3) == 0) begin
                opcode = 3'($urandom); addr1 = 4'($urandom); addr2 = 4'($urandom);
                addr3OuImm = 7'($urandom);
            end
            cpu_on      = ($urandom_range(0, 9) != 0);
            instr_ready = ($urandom_range(0, 3) == 0);
            rst         = ($urandom_range(0, 249) == 0);
            step();
        end
        rst = 1'b0; instr_ready = 1'b0; ligar = 1'b1; enviar = 1'b1;
        steps(12);
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        n_cmp = 0;
        n_fail = 0;
        cur_test = "init";
        model_reset();
        rst = 1'b1; ligar = 1'b1; enviar = 1'b1; cpu_on = 1'b0; instr_ready = 1'b0;
        opcode = '0; addr1 = '0; addr2 = '0; addr3OuImm = '0;
        test_reset();
        test_clean_send();
        test_bounce();
        test_overrun();
        test_power_off();
        test_coincident();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/module_input_capture.md
# module_input_capture

Front-end input stage of the mini CPU. Synchronises and debounces the two active-low push buttons, `ligar` and `enviar`. Produces a one-cycle power-toggle pulse on each `ligar` release. On each `enviar` release it latches the switch fields `opcode`, `addr1`, `addr2` and `addr3OuImm` into a held instruction and offers it to the CPU FSM over a valid/ready handshake. The CPU consumes it in FETCH and needs no button-edge logic of its own.

## Interface
- `DEBOUNCE_CYCLES`, default 50000: consecutive stable cycles required before a debounced level changes. Minimum 1. Counter width is `$clog2(DEBOUNCE_CYCLES+1)`.
- `clk`  in  1  system clock; all logic on posedge.
- `rst`  in  1  reset; synchronous, active-high.
- `ligar`  in  1  raw power button; 0 = pressed.
- `enviar`  in  1  raw send button; 0 = pressed.
- `opcode`  in  3  raw opcode switches.
- `addr1`  in  4  raw source-1 address switches.
- `addr2`  in  4  raw source-2 address switches.
- `addr3OuImm`  in  7  raw destination/immediate switches.
- `cpu_on`  in  1  1 while the CPU is not in OFF.
- `instr_ready`  in  1  CPU accepts the held instruction this cycle.
- `power_toggle`  out  1  one-cycle pulse per debounced `ligar` release.
- `instr_valid`  out  1  held instruction available.
- `instr_opcode`  out  3  latched opcode.
- `instr_addr1`  out  4  latched `addr1`.
- `instr_addr2`  out  4  latched `addr2`.
- `instr_addr3OuImm`  out  7  latched `addr3OuImm`.
- `overrun`  out  1  sticky: an `enviar` release was discarded because an instruction was still held.

## Operation
- **Synchroniser.** Each button passes through a 2-flop synchroniser. The flops reset to 1 (released). Switch fields are sampled directly at the capture edge; they are quasi-static.
- **Debouncer.** One per button, with debounced level `db` (reset 1) and counter `cnt` (reset 0).
  - If the sync output equals `db`: `cnt <= 0`.
  - Otherwise, if `cnt == DEBOUNCE_CYCLES-1`: `db <= sync`, `cnt <= 0`.
  - Otherwise: `cnt <= cnt+1`.
  - Any bounce back to the `db` level before the count completes restarts the count.
- **Release event.** A release is `db & ~db_prev`, where `db_prev` is `db` registered, with reset value 1. A press (falling `db`) produces no event.
- **Power.** Each `ligar` release drives `power_toggle` high for exactly one cycle. The same event:
  - flushes the capture FSM to IDLE (`instr_valid` drops);
  - clears `overrun`.
- **Capture FSM.**
  - IDLE, on `enviar` release with `cpu_on=1` and no `ligar` release in the same cycle: latch all four switch fields into the `instr_*` outputs, go to HOLD.
  - IDLE, on `enviar` release with `cpu_on=0`: discard; `overrun` is unchanged.
  - HOLD: `instr_valid=1`. The `instr_*` outputs are frozen.
  - HOLD, on `instr_valid & instr_ready`: go to IDLE. The instruction is consumed exactly once.
  - HOLD, on `enviar` release: discard the new fields and set `overrun`. The held instruction is unchanged.
  - If an `enviar` release and a handshake occur in the same HOLD cycle, the new release is still discarded and `overrun` is set.
- **Priority when events coincide.** `rst` > `ligar` release (flush) > handshake > `enviar` capture.
- **Reset values.**
  - `power_toggle=0`, `instr_valid=0`, `overrun=0`.
  - `instr_opcode`, `instr_addr1`, `instr_addr2`, `instr_addr3OuImm` all 0.
  - FSM in IDLE; counters 0; sync, `db` and `db_prev` at 1.
- **Reset mid-operation.** Reset asserted mid-count or in HOLD returns every register to its reset value on the next edge. No release event fires on reset exit, even if a button is held.
- `cpu_on` is only sampled in IDLE at a release. A `cpu_on` drop while in HOLD does not clear the held instruction; only a `ligar` release or `rst` does.

## Timing
- A raw button transition first sampled at edge N, with no bounce, updates `db` at edge N+1+DEBOUNCE_CYCLES.
- `power_toggle`, the `instr_valid` rise and the field latch all occur at edge N+2+DEBOUNCE_CYCLES.
- `instr_valid` falls at the first edge where `instr_ready=1` was sampled with `instr_valid=1`. Minimum HOLD duration is one cycle.
- The `instr_*` outputs change only at a capture edge or at reset.
- A counter that saturates a given edge does not wrap; it returns to 0.

## Test plan
All scenarios use `DEBOUNCE_CYCLES=4`.
- **Reset values.** Hold `rst` for 3 cycles with `ligar=enviar=0` -> all outputs 0 throughout; `power_toggle` stays 0 after release of `rst`.
- **Clean send.** `cpu_on=1`; switches `opcode=3'b001`, `addr1=4'h2`, `addr2=4'h3`, `addr3OuImm=7'h28`; press `enviar` 10 cycles, then release at edge N -> `instr_valid` rises at N+6 with `instr_opcode=1`, `instr_addr1=2`, `instr_addr2=3`, `instr_addr3OuImm=0x28`; assert `instr_ready` 3 cycles later -> `instr_valid` falls on the next edge.
- **Bounce.** Toggle raw `enviar` 1,0,1,0 at 1-cycle intervals, then hold 1 -> exactly one capture; no capture occurs while the toggling is under 4 stable cycles.
- **Overrun.** Capture once, keep `instr_ready=0`, change switches to `opcode=3'b111`, send again -> held `instr_opcode` still 1, `overrun=1`; one `ligar` press/release -> `power_toggle` one cycle high, `instr_valid=0`, `overrun=0`.
- **Power off.** `cpu_on=0`, send -> no `instr_valid`, `overrun=0`.
- **Coincident releases.** Release `ligar` and `enviar` raw on the same edge with `cpu_on=1` -> `power_toggle` pulses, no capture occurs; `rst` asserted during HOLD -> `instr_valid=0` next edge.
